// File: rtl/prog_lut_neuron_pkg.sv
// Shared types and size derivations for the programmable LUT neuron.
// The table is loaded as CFG_WORDS words of CFG_W entries each.
package prog_lut_neuron_pkg;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_LOAD  = 2'd1,
        S_ARMED = 2'd2
    } state_t;

    function automatic int table_depth(input int in_bits);
        return 1 << in_bits;
    endfunction

    function automatic int cfg_words(input int in_bits, input int cfg_w);
        return table_depth(in_bits) / cfg_w;
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lut_cfg_store.sv
// Word-wide table storage: one write port and one registered read port.
// Only the read register is reset; the array itself maps onto distributed RAM.
module lut_cfg_store
    import prog_lut_neuron_pkg::*;
#(
    parameter int AW    = 5,
    parameter int W     = 8,
    parameter int DEPTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // NOTE: the array has no reset branch; resetting it would turn the RAM into flops.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // NOTE: non-blocking read of mem returns the pre-write word when a read and
    // a write hit the same cycle, which gives read-before-write ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/prog_lut_neuron.sv
// Single-bit programmable lookup neuron: a 2^IN_BITS-entry table loaded over a
// framed word stream, then queried with one-cycle registered latency.
module prog_lut_neuron
    import prog_lut_neuron_pkg::*;
#(
    parameter int IN_BITS = 8,
    parameter int CFG_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CFG_W-1:0]   cfg_data,
    input  logic               cfg_last,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_BITS-1:0] in_data,
    output logic               out_valid,
    output logic               out_data,
    output logic               table_valid,
    output logic               cfg_err
);

    localparam int CFG_WORDS = cfg_words(IN_BITS, CFG_W);
    localparam int AW        = idx_width(CFG_WORDS);
    localparam int BW        = idx_width(CFG_W);
    localparam logic [AW-1:0] LAST_IDX = AW'(CFG_WORDS - 1);

    state_t          state;
    logic [AW-1:0]   cnt;
    logic [AW-1:0]   cur_idx;
    logic [BW-1:0]   bit_q;
    logic [CFG_W-1:0] rd_word;
    logic            cfg_fire;
    logic            in_fire;

    assign cfg_ready   = 1'b1;
    assign in_ready    = (state == S_ARMED);
    assign table_valid = (state == S_ARMED);
    assign cfg_fire    = cfg_valid & cfg_ready;
    assign in_fire     = in_valid & in_ready;

    // Any beat outside LOAD starts a fresh image at word 0.
    assign cur_idx = (state == S_LOAD) ? cnt : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_EMPTY;
            cnt     <= '0;
            cfg_err <= 1'b0;
        end else if (cfg_fire) begin
            if (cur_idx == LAST_IDX) begin
                cnt <= '0;
                if (cfg_last) begin
                    state   <= S_ARMED;
                    cfg_err <= 1'b0;
                end else begin
                    state   <= S_EMPTY;
                    cfg_err <= 1'b1;
                end
            end else if (cfg_last) begin
                state   <= S_EMPTY;
                cnt     <= '0;
                cfg_err <= 1'b1;
            end else begin
                state   <= S_LOAD;
                cnt     <= cur_idx + 1'b1;
                cfg_err <= 1'b0;
            end
        end
    end

    // The bit select is registered alongside the word read so out_data holds between queries.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            bit_q     <= '0;
        end else begin
            out_valid <= in_fire;
            if (in_fire) begin
                bit_q <= in_data[BW-1:0];
            end
        end
    end

    lut_cfg_store #(
        .AW    (AW),
        .W     (CFG_W),
        .DEPTH (CFG_WORDS)
    ) u_store (
        .clk   (clk),
        .rst   (rst),
        .we    (cfg_fire),
        .waddr (cur_idx),
        .wdata (cfg_data),
        .re    (in_fire),
        .raddr (in_data[IN_BITS-1 -: AW]),
        .rdata (rd_word)
    );

    assign out_data = rd_word[bit_q];

endmodule

// File: doc/prog_lut_neuron.md
PROG_LUT_NEURON -- requirements
Module: prog_lut_neuron

Interface
REQ-001 Parameter IN_BITS, default 8, neuron input width; the table holds 2^IN_BITS entries.
REQ-002 Parameter CFG_W, default 8, configuration word width; CFG_WORDS = 2^IN_BITS / CFG_W (32 at defaults).
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cfg_valid  input  1  configuration beat valid.
REQ-006 cfg_ready  output  1  configuration beat accepted when cfg_valid&cfg_ready.
REQ-007 cfg_data  input  CFG_W  table word; bit j of word k = entry k*CFG_W+j.
REQ-008 cfg_last  input  1  marks final word of a table image.
REQ-009 in_valid  input  1  query valid.
REQ-010 in_ready  output  1  query accepted when in_valid&in_ready.
REQ-011 in_data  input  IN_BITS  query index (unsigned entry number).
REQ-012 out_valid  output  1  result valid.
REQ-013 out_data  output  1  table entry at the queried index.
REQ-014 table_valid  output  1  complete, error-free image loaded.
REQ-015 cfg_err  output  1  sticky framing error flag.

Function
REQ-016 FSM states: EMPTY, LOAD, ARMED.
REQ-017 cfg_ready SHALL be 1 in all states; beats are never stalled.
REQ-018 Accepted beat in EMPTY or ARMED: write cfg_data to word 0, word counter := 1, go to LOAD, clear cfg_err.
REQ-019 Accepted beat in LOAD: write word at counter, counter += 1; cycles without an accepted beat hold counter and contents.
REQ-020 Beat with counter = CFG_WORDS-1 and cfg_last=1: go to ARMED, table_valid := 1 the following cycle.
REQ-021 cfg_last=1 on any earlier word, or cfg_last=0 on word CFG_WORDS-1: cfg_err := 1, go to EMPTY, counter := 0.
REQ-022 in_ready = 1 only in ARMED; table_valid = 1 only in ARMED.
REQ-023 Accepted query: out_valid = 1 and out_data = entry[in_data] exactly one cycle later; otherwise out_valid = 0 and out_data holds its last value.
REQ-024 Back-to-back queries at one per cycle SHALL be supported with no bubbles.
REQ-025 Query and first config beat in the same ARMED cycle: query is accepted and returns the pre-write contents (read-before-write); in_ready = 0 from the next cycle.
REQ-026 Queries are never accepted in EMPTY or LOAD; table contents are not cleared on error or reload.

Reset
REQ-027 rst SHALL force state EMPTY, counter 0, out_valid 0, out_data 0, table_valid 0, cfg_err 0, regardless of state, including mid-load.
REQ-028 Table storage is not reset; contents are undefined until a full load completes.

Structure
REQ-029 A shared package SHALL hold the FSM state enum and the CFG_WORDS / table-depth derivation functions.
REQ-030 Storage SHALL be a CFG_WORDS x CFG_W distributed-RAM array, one write port and one registered read port, in sub-module lut_cfg_store.
REQ-031 Counter width SHALL be clog2(CFG_WORDS); no wrap beyond CFG_WORDS-1 is reachable.

Verification
REQ-032 Reset -> cfg_ready=1, in_ready=0, out_valid=0, table_valid=0, cfg_err=0.
REQ-033 Load 32 words of 0xFF, except word 18 = 0xFE, with last on word 31 -> table_valid=1 the next cycle; query 0x90 -> out_data=0 one cycle later; query 0x91 -> out_data=1.
REQ-034 cfg_last on word 10 -> cfg_err=1, state EMPTY, in_ready=0; word 31 with cfg_last=0 -> cfg_err=1.
REQ-035 Load with random cfg_valid gaps, then 256 back-to-back queries 0x00..0xFF -> 256 consecutive out_valid pulses matching the loaded image.
REQ-036 In ARMED, query 0x90 in the same cycle as a reload beat with word 0 = 0x00 -> returns the old entry value; in_ready=0 from the next cycle.
REQ-037 rst after 15 loaded words -> EMPTY, counter 0; a subsequent full load reaches ARMED with correct contents.
